// File: rtl/prog_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem_loader_if
// Brief    : Load stream, CPU memory port and dump stream of prog_mem_loader.
// Revision : 1.0
// ============================================================================
interface prog_mem_loader_if #(
   parameter int DW = 8,
   parameter int AW = 5
);
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] odata;
   logic [DW-1:0] idata;
   logic          start;
   logic          halt;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          done;

   modport master (
      output s_valid, s_data, s_last, we, addr, odata, halt, m_ready,
      input  s_ready, idata, start, m_valid, m_data, m_last, done
   );

   modport slave (
      input  s_valid, s_data, s_last, we, addr, odata, halt, m_ready,
      output s_ready, idata, start, m_valid, m_data, m_last, done
   );
endinterface
`default_nettype wire

// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem_loader
// Brief    : DEPTH x DW program memory: stream load, CPU run, stream dump.
//            Optional macro LOADER_CHECKSUM_EN appends a mod-2^DW sum beat.
// Revision : 1.0
// ============================================================================
module prog_mem_loader #(
   parameter int DW    = 8,
   parameter int AW    = 5,
   parameter int DEPTH = 32
) (
   input  wire              clk,
   input  wire              rst_n,
   prog_mem_loader_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_RUN  = 3'd2,
      S_DUMP = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);

   state_t        r_state;
   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic          r_start;
   logic          r_m_valid;
   logic [DW-1:0] r_m_data;
   logic          r_m_last;
   logic          r_done;
`ifdef LOADER_CHECKSUM_EN
   logic [DW-1:0] r_sum;
`endif

   logic          w_s_ready;
   logic          w_beat;
   logic [AW-1:0] w_wr_addr;
   logic          w_load_end;
   logic          w_cpu_wr;
   logic          w_xfer;
   logic [AW-1:0] w_rd_next;

   assign w_s_ready  = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DONE);
   assign w_beat     = bus.s_valid & w_s_ready;
   // A reload out of DONE always restarts the image at address 0.
   assign w_wr_addr  = (r_state == S_DONE) ? '0 : r_wr_ptr;
   assign w_load_end = bus.s_last | (w_wr_addr == c_LAST_ADDR);
   assign w_cpu_wr   = (r_state == S_RUN) & bus.we;
   assign w_xfer     = r_m_valid & bus.m_ready;
   assign w_rd_next  = r_rd_ptr + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_beat) begin
         r_mem[w_wr_addr] <= bus.s_data;
      end else if (w_cpu_wr) begin
         r_mem[bus.addr] <= bus.odata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_start   <= 1'b0;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_m_last  <= 1'b0;
         r_done    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         r_sum     <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_LOAD, S_DONE: begin
               if (w_beat) begin
                  r_wr_ptr <= w_wr_addr + 1'b1;
                  r_done   <= 1'b0;
                  r_state  <= w_load_end ? S_RUN : S_LOAD;
               end
            end
            S_RUN: begin
               if (!r_start) begin
                  r_start <= 1'b1;
               end else if (bus.halt) begin
                  r_start   <= 1'b0;
                  r_state   <= S_DUMP;
                  r_rd_ptr  <= '0;
                  r_m_valid <= 1'b1;
                  // Forward a CPU write to word 0 landing on the halt edge.
                  r_m_data  <= (w_cpu_wr && (bus.addr == '0)) ? bus.odata : r_mem[0];
                  r_m_last  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  r_sum     <= '0;
`endif
               end
            end
            S_DUMP: begin
               if (w_xfer) begin
                  if (r_m_last) begin
                     r_state   <= S_DONE;
                     r_m_valid <= 1'b0;
                     r_m_last  <= 1'b0;
                     r_done    <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  end else if (r_rd_ptr == c_LAST_ADDR) begin
                     r_m_data <= r_sum + r_m_data;
                     r_m_last <= 1'b1;
                  end else begin
                     r_sum    <= r_sum + r_m_data;
                     r_rd_ptr <= w_rd_next;
                     r_m_data <= r_mem[w_rd_next];
                  end
`else
                  end else begin
                     r_rd_ptr <= w_rd_next;
                     r_m_data <= r_mem[w_rd_next];
                     r_m_last <= (w_rd_next == c_LAST_ADDR);
                  end
`endif
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.s_ready = w_s_ready;
   assign bus.idata   = r_mem[bus.addr];
   assign bus.start   = r_start;
   assign bus.m_valid = r_m_valid;
   assign bus.m_data  = r_m_data;
   assign bus.m_last  = r_m_last;
   assign bus.done    = r_done;

endmodule
`default_nettype wire
